// File: rtl/m_rf_mp.sv
// Multi-port register file with a per-register busy scoreboard and a sticky halt flag.
// Define M_RF_MP_BYPASS_EN to forward same-cycle write data and busy-clears to the read ports.
module m_rf_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int HALT_REG = 30
) (
  input  logic                          w_clk,
  input  logic                          w_rst_n,
  input  logic [NRD*$clog2(NREG)-1:0]   w_ra,
  output logic [NRD*XLEN-1:0]           w_rd,
  output logic [NRD-1:0]                w_rbusy,
  input  logic [NWR-1:0]                w_we,
  input  logic [NWR*$clog2(NREG)-1:0]   w_wa,
  input  logic [NWR*XLEN-1:0]           w_wd,
  input  logic                          w_bset,
  input  logic [$clog2(NREG)-1:0]       w_bset_a,
  output logic                          w_halt
);

  localparam int            AW       = $clog2(NREG);
  localparam logic [AW-1:0] HALT_IDX = AW'(HALT_REG);
  localparam bit            HALT_ON  = (HALT_REG != 0);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            halt_q, halt_d;
  logic [NWR-1:0]  wr_eff;
  logic [NREG-1:0] wr_hit;

  always_comb begin
    wr_eff = '0;
    wr_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_eff[j] = w_we[j] && (w_wa[j*AW +: AW] != '0) && !halt_q;
      if (wr_eff[j]) wr_hit[w_wa[j*AW +: AW]] = 1'b1;
    end
  end

  // Ascending port order lets the highest-numbered port win an address collision.
  always_comb begin
    for (int k = 0; k < NREG; k++) mem_d[k] = mem_q[k];
    for (int j = 0; j < NWR; j++) begin
      if (wr_eff[j]) mem_d[w_wa[j*AW +: AW]] = w_wd[j*XLEN +: XLEN];
    end
    mem_d[0] = '0;
  end

  // A new producer issued on the same edge as the old result lands keeps the register busy.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (w_bset && !halt_q && (w_bset_a != '0)) busy_d[w_bset_a] = 1'b1;
    busy_d[0] = 1'b0;
    halt_d = halt_q | (HALT_ON && wr_hit[HALT_IDX]);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int k = 0; k < NREG; k++) mem_q[k] <= '0;
      busy_q <= '0;
      halt_q <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) mem_q[k] <= mem_d[k];
      busy_q <= busy_d;
      halt_q <= halt_d;
    end
  end

  assign w_halt = halt_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            busy;

    assign ra = w_ra[i*AW +: AW];

    always_comb begin
      data = mem_q[ra];
      busy = busy_q[ra];
`ifdef M_RF_MP_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wr_eff[j] && (w_wa[j*AW +: AW] == ra)) data = w_wd[j*XLEN +: XLEN];
      end
      busy = busy & ~wr_hit[ra];
`else
      busy = busy;
`endif
      if (ra == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign w_rd[i*XLEN +: XLEN] = data;
    assign w_rbusy[i]           = busy;
  end

endmodule

// File: tb/tb_m_rf_mp.sv
// Self-checking bench for m_rf_mp: stimulus table with a queue of expected outputs,
// plus hand-written reset-mid-operation sequences. Expectations adapt to M_RF_MP_BYPASS_EN.
module tb_m_rf_mp;

`ifdef M_RF_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic [9:0]  w_ra;
  logic [63:0] w_rd;
  logic [1:0]  w_rbusy;
  logic [1:0]  w_we;
  logic [9:0]  w_wa;
  logic [63:0] w_wd;
  logic        w_bset;
  logic [4:0]  w_bset_a;
  logic        w_halt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        bset;
    logic [4:0]  bseta;
    logic [4:0]  ra0, ra1;
    logic [31:0] erd0, erd1;
    logic [1:0]  ebusy;
    logic        ehalt;
  } vec_t;

  typedef struct {
    logic [31:0] rd0, rd1;
    logic [1:0]  busy;
    logic        halt;
  } exp_t;

  exp_t expQ[$];
  vec_t vecs[19];

  m_rf_mp dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_ra    (w_ra),
    .w_rd    (w_rd),
    .w_rbusy (w_rbusy),
    .w_we    (w_we),
    .w_wa    (w_wa),
    .w_wd    (w_wd),
    .w_bset  (w_bset),
    .w_bset_a(w_bset_a),
    .w_halt  (w_halt)
  );

  always #5 w_clk = ~w_clk;

  function automatic vec_t mkVec(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                                 logic [4:0] wa1, logic [31:0] wd1, logic bset,
                                 logic [4:0] bseta, logic [4:0] ra0, logic [4:0] ra1,
                                 logic [31:0] erd0, logic [31:0] erd1,
                                 logic [1:0] ebusy, logic ehalt);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.bset = bset; v.bseta = bseta; v.ra0 = ra0; v.ra1 = ra1;
    v.erd0 = erd0; v.erd1 = erd1; v.ebusy = ebusy; v.ehalt = ehalt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expected outputs.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge w_clk);
    w_we     = v.we;
    w_wa     = {v.wa1, v.wa0};
    w_wd     = {v.wd1, v.wd0};
    w_bset   = v.bset;
    w_bset_a = v.bseta;
    w_ra     = {v.ra1, v.ra0};
    e.rd0 = v.erd0; e.rd1 = v.erd1; e.busy = v.ebusy; e.halt = v.ehalt;
    expQ.push_back(e);
  endtask

  task automatic checkVector(input string tag);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s queue: got empty expected entry", tag);
      return;
    end
    checks--;
    e = expQ.pop_front();
    checkOutput({tag, " rd0"},   w_rd[31:0],         e.rd0);
    checkOutput({tag, " rd1"},   w_rd[63:32],        e.rd1);
    checkOutput({tag, " rbusy"}, {30'd0, w_rbusy},   {30'd0, e.busy});
    checkOutput({tag, " halt"},  {31'd0, w_halt},    {31'd0, e.halt});
  endtask

  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v);
    #2;
    checkVector(tag);
  endtask

  initial begin
    vecs[0]  = mkVec(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                     32'h0, 32'h0, 2'b00, 1'b0);
    vecs[1]  = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                     32'h0, 32'h0, 2'b00, 1'b0);
    vecs[2]  = mkVec(2'b11, 5'd5, 32'h1234_5678, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd0,
                     BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0, 2'b00, 1'b0);
    vecs[3]  = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5,
                     32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 1'b0);
    vecs[4]  = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd5,
                     32'h0, 32'hDEAD_BEEF, 2'b00, 1'b0);
    vecs[5]  = mkVec(2'b01, 5'd7, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                     BYP ? 32'hA5 : 32'h0, BYP ? 32'hA5 : 32'h0, BYP ? 2'b00 : 2'b11, 1'b0);
    vecs[6]  = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                     32'hA5, 32'h0, 2'b00, 1'b0);
    vecs[7]  = mkVec(2'b10, 5'd0, 32'h0, 5'd9, 32'h1, 1'b1, 5'd9, 5'd9, 5'd9,
                     BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0, 2'b00, 1'b0);
    vecs[8]  = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5,
                     32'h1, 32'hDEAD_BEEF, 2'b01, 1'b0);
    vecs[9]  = mkVec(2'b01, 5'd9, 32'h22, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9,
                     32'hDEAD_BEEF, BYP ? 32'h22 : 32'h1, BYP ? 2'b00 : 2'b10, 1'b0);
    vecs[10] = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                     32'h22, 32'h22, 2'b00, 1'b0);
    vecs[11] = mkVec(2'b11, 5'd12, 32'hAAAA, 5'd13, 32'hBBBB, 1'b1, 5'd0, 5'd12, 5'd13,
                     BYP ? 32'hAAAA : 32'h0, BYP ? 32'hBBBB : 32'h0, 2'b00, 1'b0);
    vecs[12] = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd12,
                     32'h0, 32'hAAAA, 2'b00, 1'b0);
    vecs[13] = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd13, 5'd0,
                     32'hBBBB, 32'h0, 2'b00, 1'b0);
    vecs[14] = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0,
                     32'h0, 32'h0, 2'b00, 1'b0);
    vecs[15] = mkVec(2'b01, 5'd30, 32'h42, 5'd0, 32'h0, 1'b0, 5'd0, 5'd30, 5'd3,
                     BYP ? 32'h42 : 32'h0, 32'h0, 2'b10, 1'b0);
    vecs[16] = mkVec(2'b11, 5'd3, 32'h9, 5'd30, 32'h99, 1'b1, 5'd11, 5'd3, 5'd30,
                     32'h0, 32'h42, 2'b01, 1'b1);
    vecs[17] = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd11,
                     32'h0, 32'h0, 2'b01, 1'b1);
    vecs[18] = mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd30, 5'd5,
                     32'h42, 32'hDEAD_BEEF, 2'b00, 1'b1);

    w_rst_n = 1'b0; w_we = '0; w_wa = '0; w_wd = '0;
    w_bset = 1'b0; w_bset_a = '0; w_ra = {5'd7, 5'd5};
    @(negedge w_clk);
    checkOutput("reset rd0",   w_rd[31:0],          32'h0);
    checkOutput("reset rbusy", {30'd0, w_rbusy},    32'h0);
    checkOutput("reset halt",  {31'd0, w_halt},     32'h0);
    #2 w_rst_n = 1'b1;

    for (int a = 0; a < 32; a += 2) begin
      runVector(mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(a + 1),
                      32'h0, 32'h0, 2'b00, 1'b0), $sformatf("scan x%0d", a));
    end

    for (int i = 0; i < 19; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset between edges clears halt and storage immediately.
    #1 w_rst_n = 1'b0;
    #1;
    checkOutput("rstpulse rd0 x30", w_rd[31:0],       32'h0);
    checkOutput("rstpulse rd1 x5",  w_rd[63:32],      32'h0);
    checkOutput("rstpulse halt",    {31'd0, w_halt},  32'h0);
    @(negedge w_clk);
    #1 w_rst_n = 1'b1;

    runVector(mkVec(2'b01, 5'd4, 32'h77, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4,
                    BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, 2'b00, 1'b0), "x4 write");
    runVector(mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0,
                    32'h77, 32'h0, 2'b01, 1'b0), "x4 read");

    // In-flight write to x6 held across an edge while reset is low must be discarded.
    #1;
    w_we = 2'b01; w_wa = {5'd0, 5'd6}; w_wd = {32'h0, 32'h5}; w_ra = {5'd6, 5'd4};
    w_rst_n = 1'b0;
    #1;
    checkOutput("midrst rd0 x4", w_rd[31:0],      32'h0);
    checkOutput("midrst rbusy",  {30'd0, w_rbusy}, 32'h0);
    checkOutput("midrst halt",   {31'd0, w_halt},  32'h0);
    @(negedge w_clk);
    w_we = 2'b00;
    #1 w_rst_n = 1'b1;

    runVector(mkVec(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd4,
                    32'h0, 32'h0, 2'b00, 1'b0), "post-reset x6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_rf_mp.md
Name: m_rf_mp

Overview:
Parametrised multi-port integer register file with write-to-read bypass, per-register busy scoreboard and a registered halt flag.
- Next-generation RF for the core: supports NRD read and NWR write ports, so dual-issue or multi-cycle units can share one file.
- The scoreboard lets issue logic stall on pending producers.
- The halt flag replaces simulation-only termination with a synthesisable, observable output.

Parameters:
XLEN, 32, data width in bits.
NREG, 32, number of architectural registers (power of 2, >=2); AW = $clog2(NREG) is a localparam.
NRD, 2, number of read ports.
NWR, 2, number of write ports.
HALT_REG, 30, register index whose committed write raises w_halt.

Ports:
w_clk  in  1  clock; all state updates on the rising edge.
w_rst_n  in  1  reset, asynchronous, active-low.
w_ra  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
w_rd  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
w_rbusy  out  NRD  busy status of the register addressed by each read port.
w_we  in  NWR  write enables.
w_wa  in  NWR*AW  write addresses.
w_wd  in  NWR*XLEN  write data.
w_bset  in  1  mark a register busy (producer issued).
w_bset_a  in  AW  register index to mark busy.
w_halt  out  1  sticky halt flag, registered.

Behaviour:
- Reset (w_rst_n=0, asynchronous):
  - all NREG registers become 0;
  - all busy bits become 0;
  - w_halt becomes 0.
  - Reset asserted mid-operation discards any in-flight write on that edge.
- Register 0:
  - always reads 0 and never reads busy;
  - writes and w_bset targeting index 0 are ignored.
- Effective write, port j:
  - condition: w_we[j] && w_wa[j]!=0 && !w_halt;
  - commits mem[w_wa[j]] <= w_wd[j] on the rising edge.
- Same-address collision: when several effective writes target one index in a cycle, the highest-numbered port wins; the other writes are dropped.
- Read (combinational, zero latency):
  - w_ra[i]==0 -> w_rd[i] = 0;
  - else, when an effective write this cycle matches w_ra[i] -> w_rd[i] = that port's data, using the highest matching port (bypass; see Optional Feature);
  - else -> w_rd[i] = mem[w_ra[i]].
- Scoreboard, per register k != 0:
  - set on an edge where w_bset && w_bset_a==k;
  - cleared on an edge with an effective write to k;
  - simultaneous set and clear on the same k: set wins, because a new producer is pending.
  - w_bset is ignored while w_halt=1.
- w_rbusy[i] = busy[w_ra[i]] && !(effective write to w_ra[i] this cycle) (bypassed clear). A w_bset issued this cycle is not visible on w_rbusy until the next cycle.
- Halt:
  - w_halt goes 1 on the edge that commits an effective write to HALT_REG; that write itself is stored.
  - Afterwards all writes and busy-sets are blocked and reads remain functional.
  - Only reset clears w_halt.
  - When HALT_REG==0, w_halt never asserts.
- No state machine beyond the halt flag (RUN -> HALTED, exit only via reset). The storage array plus busy vector are the sequential state.

Optional Feature:
- Macro: M_RF_MP_BYPASS_EN.
- Defined: write-to-read bypass of data and busy-clear exactly as described in Behaviour.
- Undefined:
  - reads return mem contents only, so written data becomes visible the cycle after the commit edge;
  - w_rbusy[i] = busy[w_ra[i]] with no same-cycle clear.
- Collision priority, scoreboard set-wins and halt behaviour are identical in both builds.

Test Plan:
- Reset, then read every index on all ports -> all w_rd=0, w_rbusy=0, w_halt=0; write x0=32'hFFFF_FFFF -> reads of x0 stay 0.
- Port0 writes x5=32'h1234_5678 while port1 writes x5=32'hDEAD_BEEF -> next cycle x5 reads 32'hDEAD_BEEF; with bypass enabled, a same-cycle read of x5 also returns 32'hDEAD_BEEF; bypass disabled -> same-cycle read returns the old value 0.
- w_bset x7; next cycle w_rbusy for x7 =1; port0 writes x7=32'hA5 -> bypass build shows w_rbusy=0 in the same cycle, busy bit 0 after the edge.
- Same cycle: w_bset x9 and port1 writes x9=32'h1 -> after the edge x9=1 and busy[x9]=1.
- Write x30=32'h42 -> w_halt=1 after the edge; a later write x3=32'h9 is ignored (x3 stays 0); x30 reads 32'h42.
- Set x4=32'h77 and busy x4, pulse w_rst_n low between clock edges -> immediately x4 reads 0, w_rbusy=0, w_halt=0.
